// File: rtl/alu32_nibble_seq.sv
// alu32_nibble_seq
//   Multi-cycle 32-bit ALU front end. It captures one operand pair and an
//   opcode per transaction, then pushes one SLICE_W-bit nibble per cycle
//   through a small slice datapath. The carry is chained between nibbles.
//   The block assembles the full result and its flags for the consumer.
//
//   Ports
//     i_clk     rising-edge clock
//     i_rst     synchronous, active-high reset
//     i_start   request, accepted only while o_busy = 0
//     i_op      000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (optional)
//     i_a, i_b  operands, sampled on accept
//     o_busy    high in RUN and DONE
//     o_done    one-cycle pulse when the result is valid
//     o_result  assembled result, held until the next accept
//     o_carry   carry-out of the MSB nibble (ADD/SUB), 0 for logic ops
//     o_zero    result == 0, valid with o_done and held
//     o_err     illegal opcode flag, valid with o_done and held
//
//   Optional feature macro: ALU_SUB_EN adds op 100 = a - b (a + ~b + 1).
//
//   state  | meaning
//   IDLE   | waiting for i_start
//   RUN    | one nibble processed per cycle, idx 0..NSLICE-1
//   DONE   | o_done pulse, result and flags valid
module alu32_nibble_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_err
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry_int;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic              r_zero;
  logic              r_err;
  logic              r_done;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_b_eff;
  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_slice;
  logic               w_arith;
  logic               w_illegal;
  logic               w_last;
  logic               w_seed;
  logic [DATA_W-1:0]  w_result_next;

  assign w_a_nib = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_b_nib = r_b[int'(r_idx)*SLICE_W +: SLICE_W];

`ifdef ALU_SUB_EN
  // Subtraction reuses the adder: invert B per nibble, seed carry with 1.
  assign w_b_eff   = (r_op == OP_SUB) ? ~w_b_nib : w_b_nib;
  assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_illegal = (r_op > OP_SUB);
  assign w_seed    = (i_op == OP_SUB);
`else
  assign w_b_eff   = w_b_nib;
  assign w_arith   = (r_op == OP_ADD);
  assign w_illegal = (r_op > OP_ADD);
  assign w_seed    = 1'b0;
`endif

  assign w_sum  = {1'b0, w_a_nib} + {1'b0, w_b_eff} + {{SLICE_W{1'b0}}, r_carry_int};
  assign w_last = (r_idx == IDXW'(NSLICE - 1));

  always_comb begin
    w_slice = '0;
    case (r_op)
      OP_AND:  w_slice = w_a_nib & w_b_nib;
      OP_OR:   w_slice = w_a_nib | w_b_nib;
      OP_XOR:  w_slice = w_a_nib ^ w_b_nib;
      default: w_slice = w_arith ? w_sum[SLICE_W-1:0] : '0;
    endcase
  end

  // The full next result is needed on the last nibble for the zero flag.
  always_comb begin
    w_result_next = r_result;
    w_result_next[int'(r_idx)*SLICE_W +: SLICE_W] = w_slice;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_carry_int <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a         <= i_a;
            r_b         <= i_b;
            r_op        <= i_op;
            r_result    <= '0;
            r_idx       <= '0;
            r_carry_int <= w_seed;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_result_next;
          if (w_arith) r_carry_int <= w_sum[SLICE_W];
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_idx   <= '0;
            r_carry <= w_arith ? w_sum[SLICE_W] : 1'b0;
            r_zero  <= (w_result_next == '0);
            r_err   <= w_illegal;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_zero   = r_zero;
  assign o_err    = r_err;

endmodule
